// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to the TX and RX FSMs)
// and the baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per line bit; integer divide, caller guarantees the result is >= 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_tick on the terminal count; clr restarts the period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 2,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    logic [CNT_W-1:0] baud_cnt;

    assign bit_tick = en && (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (clr || bit_tick || !en) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to include the parity bit (PARITY_ODD selects odd).
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tx_d;
    logic                 bit_tick;
    logic                 handshake;
    logic                 state_change;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign tx_ready     = (state_q == IDLE);
    assign tx_busy      = (state_q != IDLE);
    assign handshake    = tx_valid && tx_ready;
    assign state_change = (state_d != state_q);
    assign tx_done      = (state_q == STOP) && bit_tick && (bit_cnt_q == LAST_STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tx_busy),
        .clr      (state_change),
        .bit_tick (bit_tick)
    );

    // State register plus datapath flops; tx resets high so an abort idles the pin at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx        <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (handshake) state_d = START;
            START:  if (bit_tick)  state_d = DATA;
            DATA: begin
                if (bit_tick && (bit_cnt_q == LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) state_d = STOP;
`endif
            STOP:   if (bit_tick && (bit_cnt_q == LAST_STOP)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tx is computed from the next state so the pin changes on the same edge as the state.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (handshake) begin
            shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
            parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end else if ((state_q == DATA) && bit_tick) begin
            shift_d = shift_q >> 1;
        end

        if (state_change) begin
            bit_cnt_d = '0;
        end else if (bit_tick && ((state_q == DATA) || (state_q == STOP))) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm at 10 clocks per bit; table-driven frames
// plus hand-written reset-abort and input-toggling sequences.
module tb_uart_tx_fsm;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + 8 + P + 1;
    localparam int FRAME = NBITS * CPB;

    logic       clk;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [0:7] bits;  // data bits in wire order (LSB first), hand-written
        logic       par;   // even parity bit
        bit         hold;  // keep tx_valid high and present the next row's byte
    } vec_t;

    vec_t vecs [8];

    uart_tx_fsm #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present a byte at a falling edge; the following rising edge is the handshake.
    task automatic handshake(input logic [7:0] data, input string name);
        @(negedge clk);
        check({name, " ready before send"}, tx_ready, 1'b1);
        tx_valid = 1'b1;
        tx_data  = data;
        @(posedge clk);
    endtask

    // Sample every cycle of a frame whose handshake edge has just passed.
    task automatic check_frame(input vec_t v, input logic [7:0] next_data,
                               input bit toggle, input string name);
        int   line_bad = 0;
        int   busy_bad = 0;
        int   done_cnt = 0;
        int   done_at  = -1;
        int   idx;
        logic exp_bit;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            idx = k / CPB;
            if (idx == 0)          exp_bit = 1'b0;
            else if (idx <= 8)     exp_bit = v.bits[idx-1];
            else if (idx == 9 && P == 1) exp_bit = v.par;
            else                   exp_bit = 1'b1;
            if (tx !== exp_bit) line_bad++;
            if (tx_busy !== 1'b1 || tx_ready !== 1'b0) busy_bad++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (toggle) begin
                tx_valid = (k == FRAME - 1) ? 1'b0 : 1'($urandom);
                tx_data  = 8'($urandom);
            end else if (v.hold) begin
                if (k == 50) tx_data = next_data;
            end else if (k == 0) begin
                tx_valid = 1'b0;
            end
        end
        check({name, " line bits"}, line_bad, 0);
        check({name, " busy/ready in frame"}, busy_bad, 0);
        check({name, " tx_done count"}, done_cnt, 1);
        check({name, " tx_done cycle"}, done_at, FRAME - 1);
        @(negedge clk);
        check({name, " ready after done"}, tx_ready, 1'b1);
        check({name, " idle line after done"}, {tx, tx_busy, tx_done}, 3'b100);
    endtask

    initial begin
        bit   need_hs;
        int   bad_tx, bad_ready, bad_busy, bad_done;
        int   done_in_rst;
        vec_t v3c;

        vecs[0] = '{data: 8'h55, bits: 8'b10101010, par: 1'b0, hold: 1'b0};
        vecs[1] = '{data: 8'h07, bits: 8'b11100000, par: 1'b1, hold: 1'b0};
        vecs[2] = '{data: 8'h03, bits: 8'b11000000, par: 1'b0, hold: 1'b0};
        vecs[3] = '{data: 8'h00, bits: 8'b00000000, par: 1'b0, hold: 1'b0};
        vecs[4] = '{data: 8'hFF, bits: 8'b11111111, par: 1'b0, hold: 1'b0};
        vecs[5] = '{data: 8'h80, bits: 8'b00000001, par: 1'b1, hold: 1'b0};
        vecs[6] = '{data: 8'hA3, bits: 8'b11000101, par: 1'b0, hold: 1'b1};
        vecs[7] = '{data: 8'h0F, bits: 8'b11110000, par: 1'b0, hold: 1'b0};
        v3c     = '{data: 8'h3C, bits: 8'b00111100, par: 1'b0, hold: 1'b0};

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #23;
        check("reset outputs {tx,ready,busy,done}", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle line for 100 cycles after reset release.
        bad_tx = 0; bad_ready = 0; bad_busy = 0; bad_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1)       bad_tx++;
            if (tx_ready !== 1'b1) bad_ready++;
            if (tx_busy !== 1'b0)  bad_busy++;
            if (tx_done !== 1'b0)  bad_done++;
        end
        check("idle tx high", bad_tx, 0);
        check("idle ready", bad_ready, 0);
        check("idle busy", bad_busy, 0);
        check("idle done", bad_done, 0);

        // Table of frames; row 6 runs straight into row 7 with tx_valid held.
        need_hs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            string name;
            name = $sformatf("frame %02h", vecs[i].data);
            if (need_hs) handshake(vecs[i].data, name);
            check_frame(vecs[i], (i < 7) ? vecs[i+1].data : 8'h00, 1'b0, name);
            need_hs = !vecs[i].hold;
        end

        // Abort by reset 45 cycles into a frame of 0x00 (line is low in data bit 3).
        handshake(8'h00, "abort");
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (44) @(negedge clk);
        check("abort line low before reset", tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort async tx high", tx, 1'b1);
        check("abort async busy low", tx_busy, 1'b0);
        check("abort async ready", tx_ready, 1'b1);
        done_in_rst = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx !== 1'b1) done_in_rst++;
            if (k == 2) rst_n = 1'b1;
        end
        check("abort no done, line idle", done_in_rst, 0);
        handshake(vecs[0].data, "post-abort 55");
        check_frame(vecs[0], 8'h00, 1'b0, "post-abort 55");

        // Toggle tx_valid/tx_data throughout a frame; the byte on the line must not change.
        handshake(v3c.data, "toggle 3C");
        check_frame(v3c, 8'h00, 1'b1, "toggle 3C");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
